// File: rtl/mul_seq_ctrl.sv
// Shift-and-add sequencer for an unsigned WIDTH x WIDTH multiply, using an
// external shared WIDTH-bit adder for one partial-product step per clock.
`timescale 1ns/1ps

module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_RUN  | one shift-and-add step per clock, WIDTH steps total
  // S_DONE | product valid, done pulse; start here chains the next multiply
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   hi, lo, mcand;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] product_q;
  logic [2*WIDTH-1:0] step_val;
  logic               load, step, last;

  // Carry out of the adder becomes the top bit of the shifted accumulator.
  assign step_val = {add_cout, add_sum, lo[WIDTH-1:1]};
  assign last     = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start == 1'b1) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start == 1'b1) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi        <= '0;
      lo        <= '0;
      mcand     <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else if (load) begin
      mcand <= op_a;
      lo    <= op_b;
      hi    <= '0;
      cnt   <= '0;
    end else if (step) begin
      {hi, lo} <= step_val;
      cnt      <= cnt + 1'b1;
      if (last) begin
        product_q <= step_val;
      end
    end
  end

  assign busy    = (state == S_RUN);
  assign done    = (state == S_DONE);
  assign product = product_q;

  // Adder is idle (0 + 0) outside RUN so the shared carry chain sees no activity.
  assign add_a   = busy ? hi : '0;
  assign add_b   = (busy && lo[0]) ? mcand : '0;
  assign add_cin = 1'b0;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized self-checking bench for mul_seq_ctrl; models the shared adder and
// checks every RUN cycle against plain 64-bit arithmetic.
`timescale 1ns/1ps

module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [63:0] product;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] prev = '0;

  always #5 clk = ~clk;

  // External shared adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  mul_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Upper accumulator half after i steps: (a * (b mod 2^i)) / 2^i
  function automatic logic [63:0] part_hi(input logic [31:0] a, input logic [31:0] b, input int i);
    logic [63:0] m;
    m = (i == 0) ? 64'd0 : (64'(b) & ((64'd1 << i) - 64'd1));
    return (64'(a) * m) >> i;
  endfunction

  // Entered with start already driven for operands a,b before the accepting edge.
  task automatic track(input logic [31:0] a, input logic [31:0] b, input bit inject,
                       input int abort_at, input bit chain,
                       input logic [31:0] na, input logic [31:0] nb);
    logic [63:0] exp;
    exp = 64'(a) * 64'(b);
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("busy_run", {63'd0, busy}, 64'd1);
      chk("done_run", {63'd0, done}, 64'd0);
      chk("prod_hold", product, prev);
      chk("cin", {63'd0, add_cin}, 64'd0);
      chk("add_b", {32'd0, add_b}, b[i] ? {32'd0, a} : 64'd0);
      chk("add_a", {32'd0, add_a}, part_hi(a, b, i));
      if (inject && i == 10) begin
        start = 1'b1;
        op_a  = $urandom;
        op_b  = $urandom;
      end
      if (inject && i == 11) start = 1'b0;
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_prod", product, 64'd0);
        prev = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("busy_done", {63'd0, busy}, 64'd0);
    chk("product", product, exp);
    prev = exp;
    if (chain) begin
      start = 1'b1;
      op_a  = na;
      op_b  = nb;
    end else begin
      @(negedge clk);
      chk("done_once", {63'd0, done}, 64'd0);
      chk("busy_idle", {63'd0, busy}, 64'd0);
      chk("prod_idle", product, exp);
    end
  endtask

  task automatic mul(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    track(a, b, 1'b0, -1, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, na, nb;
    bit          ch;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_prod", product, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    chk("post_rst_adder", {add_b, add_a}, 64'd0);

    mul(32'd3, 32'd5);
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mul(32'h8000_0000, 32'd2);
    mul(32'd0, 32'hDEAD_BEEF);
    mul(32'h1234_5678, 32'd1);

    // start during RUN is ignored
    start = 1'b1; op_a = 32'd7; op_b = 32'd9;
    track(32'd7, 32'd9, 1'b1, -1, 1'b0, 32'd0, 32'd0);

    // back-to-back with start in the DONE cycle
    start = 1'b1; op_a = 32'd7; op_b = 32'd9;
    track(32'd7, 32'd9, 1'b0, -1, 1'b1, 32'h1_0000, 32'h1_0000);
    track(32'h1_0000, 32'h1_0000, 1'b0, -1, 1'b0, 32'd0, 32'd0);

    // asynchronous reset mid-operation
    a = $urandom; b = $urandom;
    start = 1'b1; op_a = a; op_b = b;
    track(a, b, 1'b0, 15, 1'b0, 32'd0, 32'd0);
    start = 1'b0;
    @(negedge clk);
    mul(32'd6, 32'd7);

    a = $urandom; b = $urandom;
    start = 1'b1; op_a = a; op_b = b;
    for (int n = 0; n < 12; n++) begin
      ch = (n < 11) && ($urandom_range(0, 1) == 1);
      na = $urandom;
      nb = (n % 4 == 3) ? 32'hFFFF_FFFF : $urandom;
      track(a, b, 1'b0, -1, ch, na, nb);
      a = na;
      b = nb;
      if (!ch && n < 11) begin
        start = 1'b1; op_a = a; op_b = b;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
